load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Data-side load/store unit between the core execute stage and the byte-lane data memory.
//  Accepts one load/store request at a time and checks alignment and funct3.
//  Drives the 4-byte-lane memory port (mem_addr, mem_data_in, mem_data_out, mem_write_en).
//  Sub-word stores use read-modify-write, because the memory has a single word-wide write enable.
//  Returns sign/zero-extended load data, or an error flag, over a valid/ready response channel.
// PARAMETERS
//  MEM_LAT  1  memory read latency in cycles (legal range 1..15); mem_data_out is valid MEM_LAT cycles after mem_addr
// PORTS
//  clk           in   1      clock, rising edge
//  rst_b         in   1      asynchronous active-low reset
//  req_valid     in   1      request valid
//  req_ready     out  1      request accepted when req_valid & req_ready at a clk edge
//  req_we        in   1      1 = store, 0 = load
//  req_funct3    in   3      RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_addr      in   32     byte address
//  req_wdata     in   32     store data; low bits used for B/H
//  rsp_valid     out  1      response valid; held until rsp_ready
//  rsp_ready     in   1      response consumed when rsp_valid & rsp_ready at a clk edge
//  rsp_rdata     out  32     extended load data; 0 for stores and errors
//  rsp_err       out  1      misaligned access or illegal funct3
//  mem_addr      out  32     word address, {req_addr[31:2],2'b00}
//  mem_data_out  in   8x4    read data [0:3]; lane i = byte at mem_addr+i (little-endian)
//  mem_data_in   out  8x4    write data [0:3], same lane mapping
//  mem_write_en  out  1      writes all 4 lanes at the clk edge
// BEHAVIOUR
//  Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0,
//   mem_addr=0, mem_data_in lanes=0, mem_write_en=0.
//  Request capture: on accept, addr, funct3, we and wdata are registered; inputs are ignored afterwards.
//  req_ready is 1 only in IDLE.
//  Errors: illegal = funct3 in {011,110,111}, or a store with funct3[2]=1.
//   Misaligned = H/HU with addr[0]=1, or W with addr[1:0]!=0.
//   An error goes IDLE->RESP with rsp_err=1 and makes no memory access.
//  States:
//   IDLE -> RD_WAIT : load, or B/H store, legal.
//   IDLE -> WRITE   : W store, legal.
//   IDLE -> RESP    : error.
//   RD_WAIT -> RESP  : after MEM_LAT cycles, load.
//   RD_WAIT -> WRITE : after MEM_LAT cycles, B/H store.
//   WRITE -> RESP    : always, after exactly 1 cycle.
//   RESP -> IDLE     : on rsp_ready.
//  RD_WAIT: a 4-bit counter counts MEM_LAT cycles.
//   mem_data_out is sampled at the edge that ends the MEM_LAT-th RD_WAIT cycle.
//  Load extract: byte lane = addr[1:0]; half lanes = {addr[1],0} and {addr[1],1}.
//   B/H sign-extend; BU/HU zero-extend; W returns {lane3,lane2,lane1,lane0}.
//  Store merge: the sampled word is overwritten only in the addressed lanes.
//   SW writes req_wdata directly.
//  mem_write_en is 1 only while state==WRITE, decoded from state.
//   Reset mid-operation therefore drops it asynchronously with no partial write.
//  mem_addr and mem_data_in are registered and hold their last value outside active states.
//  Latency, counted from the accept edge to rsp_valid high:
//   load             MEM_LAT+1 cycles
//   SW               2 cycles
//   SB/SH            MEM_LAT+2 cycles
//   error            1 cycle
//  Backpressure: in RESP, rsp_valid, rsp_rdata and rsp_err are held stable until rsp_ready.
//   The next request is accepted no earlier than the edge after the one that consumes the response.
//  Reset at any time: all outputs return to reset values and any pending response is discarded.
// TESTING
//  T1 load extension, MEM_LAT=1, word 0x100=0x8899AABB:
//   LB 0x103 -> 0xFFFFFF88; LBU 0x103 -> 0x00000088;
//   LH 0x102 -> 0xFFFF8899; HU 0x100 -> 0x0000AABB; LW 0x100 -> 0x8899AABB;
//   rsp_valid 2 cycles after accept each time.
//  T2 SB 0x101, wdata 0x123456CC, on 0x8899AABB -> one read, then mem_write_en high exactly 1 cycle;
//   memory = 0x8899CCBB; rsp_err=0.
//  T3 SW 0x104, 0xDEADBEEF -> no RD_WAIT; mem_write_en high 1 cycle; rsp_valid 2 cycles after accept;
//   with MEM_LAT=3, LW 0x104 -> 0xDEADBEEF, rsp_valid 4 cycles after accept.
//  T4 errors: LW 0x102, SH 0x101, funct3=011, store funct3=100 -> rsp_err=1, rsp_rdata=0,
//   mem_write_en never high, memory unchanged, rsp_valid 1 cycle after accept.
//  T5 rsp_ready held 0 for 5 cycles after LH -> rsp_valid/rsp_rdata stable and req_ready=0 throughout;
//   a new request is accepted only after the consume edge.
//  T6 rst_b low during the WRITE cycle of SH 0x102 -> mem_write_en falls with no clock edge;
//   memory unchanged; after release req_ready=1 and rsp_valid=0.

Source files
------------

// File: rtl/load_store_unit.sv
// Data-side load/store unit between the execute stage and a 4-lane byte memory.
// Handles one request at a time; sub-word stores are done as read-modify-write
// because the memory only has a single word-wide write enable.
// Ports:
//   clk, rst_b                       clock and asynchronous active-low reset
//   req_valid/req_ready              request handshake
//   req_we, req_funct3, req_addr,    request payload (store flag, RISC-V width code,
//   req_wdata                        byte address, store data)
//   rsp_valid/rsp_ready              response handshake, held until consumed
//   rsp_rdata, rsp_err               extended load data / error flag
//   mem_addr, mem_data_out,          word-aligned memory port, lane i = byte at
//   mem_data_in, mem_write_en        mem_addr+i
module load_store_unit #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  input  logic [7:0]  mem_data_out [0:3],
  output logic [7:0]  mem_data_in  [0:3],
  output logic        mem_write_en
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(MEM_LAT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_WRITE,
    ST_RESP
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [1:0]         addr_lo_q;
  logic [2:0]         f3_q;
  logic               we_q;
  logic [15:0]        wdata_lo_q;

  logic               req_err;
  logic               illegal;
  logic               misaligned;
  logic [31:0]        rd_word;
  logic [7:0]         rd_byte;
  logic [15:0]        rd_half;
  logic [31:0]        load_data;
  logic [31:0]        merge_word;

  // Request validity check on the incoming payload
  always_comb begin
    illegal    = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11) ||
                 (req_we && req_funct3[2]);
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                 ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
    req_err    = illegal || misaligned;
  end

  // Load extraction and store lane merge from the sampled memory word
  always_comb begin
    rd_word   = {mem_data_out[3], mem_data_out[2], mem_data_out[1], mem_data_out[0]};
    rd_byte   = rd_word[{addr_lo_q, 3'b000} +: 8];
    rd_half   = rd_word[{addr_lo_q[1], 4'b0000} +: 16];
    load_data = '0;
    case (f3_q)
      3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
      3'b010:  load_data = rd_word;
      3'b100:  load_data = {24'd0, rd_byte};
      3'b101:  load_data = {16'd0, rd_half};
      default: load_data = '0;
    endcase
    merge_word = rd_word;
    if (f3_q[1:0] == 2'b00) begin
      merge_word[{addr_lo_q, 3'b000} +: 8] = wdata_lo_q[7:0];
    end else begin
      merge_word[{addr_lo_q[1], 4'b0000} +: 16] = wdata_lo_q;
    end
  end

  // Write strobe is a pure state decode so reset removes it without a clock edge
  assign mem_write_en = (state_q == ST_WRITE);

  // Control FSM with registered outputs
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_lo_q  <= '0;
      f3_q       <= '0;
      we_q       <= 1'b0;
      wdata_lo_q <= '0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      mem_addr   <= '0;
      for (int i = 0; i < 4; i++) mem_data_in[i] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            addr_lo_q  <= req_addr[1:0];
            f3_q       <= req_funct3;
            we_q       <= req_we;
            wdata_lo_q <= req_wdata[15:0];
            req_ready  <= 1'b0;
            if (req_err) begin
              state_q   <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= '0;
            end else begin
              mem_addr <= {req_addr[31:2], 2'b00};
              if (req_we && (req_funct3 == 3'b010)) begin
                state_q <= ST_WRITE;
                for (int i = 0; i < 4; i++) mem_data_in[i] <= req_wdata[8*i +: 8];
              end else begin
                state_q <= ST_RD_WAIT;
                cnt_q   <= CNT_W'(1);
              end
            end
          end
        end
        ST_RD_WAIT: begin
          if (cnt_q == LAT_CNT) begin
            if (we_q) begin
              state_q <= ST_WRITE;
              for (int i = 0; i < 4; i++) mem_data_in[i] <= merge_word[8*i +: 8];
            end else begin
              state_q   <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b0;
              rsp_rdata <= load_data;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_WRITE: begin
          state_q   <= ST_RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q   <= ST_IDLE;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            req_ready <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: one instance with MEM_LAT=1 and one with MEM_LAT=3
// share a byte-lane memory model; requests are steered by sel.
module tb_load_store_unit;

  logic        clk;
  logic        rst_b;
  logic        sel;
  logic        req_valid, req_we, rsp_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;

  logic        rr_a, rv_a, re_a, mwe_a;
  logic        rr_b, rv_b, re_b, mwe_b;
  logic [31:0] rd_a, rd_b, maddr_a, maddr_b;
  logic [7:0]  mdo_a [0:3];
  logic [7:0]  mdo_b [0:3];
  logic [7:0]  mdi_a [0:3];
  logic [7:0]  mdi_b [0:3];

  logic        o_req_ready, o_rsp_valid, o_rsp_err;
  logic [31:0] o_rsp_rdata;

  logic [31:0] mem [0:255];
  logic        mem_load;
  logic [31:0] rw_a, p1, p2, wr_word_a, wr_word_b;
  int          wr_total;

  int n_vec;
  int n_err;

  load_store_unit #(.MEM_LAT(1)) dut_a (
    .clk(clk), .rst_b(rst_b),
    .req_valid(req_valid && !sel), .req_ready(rr_a), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv_a), .rsp_ready(rsp_ready && !sel), .rsp_rdata(rd_a), .rsp_err(re_a),
    .mem_addr(maddr_a), .mem_data_out(mdo_a), .mem_data_in(mdi_a), .mem_write_en(mwe_a)
  );

  load_store_unit #(.MEM_LAT(3)) dut_b (
    .clk(clk), .rst_b(rst_b),
    .req_valid(req_valid && sel), .req_ready(rr_b), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv_b), .rsp_ready(rsp_ready && sel), .rsp_rdata(rd_b), .rsp_err(re_b),
    .mem_addr(maddr_b), .mem_data_out(mdo_b), .mem_data_in(mdi_b), .mem_write_en(mwe_b)
  );

  assign o_req_ready = sel ? rr_b : rr_a;
  assign o_rsp_valid = sel ? rv_b : rv_a;
  assign o_rsp_err   = sel ? re_b : re_a;
  assign o_rsp_rdata = sel ? rd_b : rd_a;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read for MEM_LAT=1, two-register pipe for MEM_LAT=3
  always_comb begin
    rw_a      = mem[maddr_a[9:2]];
    wr_word_a = {mdi_a[3], mdi_a[2], mdi_a[1], mdi_a[0]};
    wr_word_b = {mdi_b[3], mdi_b[2], mdi_b[1], mdi_b[0]};
    for (int i = 0; i < 4; i++) begin
      mdo_a[i] = rw_a[8*i +: 8];
      mdo_b[i] = p2[8*i +: 8];
    end
  end

  always @(posedge clk) begin
    p1 <= mem[maddr_b[9:2]];
    p2 <= p1;
    if (mwe_a || mwe_b) wr_total <= wr_total + 1;
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
      mem[64] <= 32'h8899AABB;
      mem[65] <= 32'h11223344;
    end else begin
      if (mwe_a) mem[maddr_a[9:2]] <= wr_word_a;
      if (mwe_b) mem[maddr_b[9:2]] <= wr_word_b;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One transaction: drive at negedge, count negedges from accept until rsp_valid
  task automatic txn(input bit s, input bit we, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] wd, input bit consume,
                     output logic [31:0] rd, output bit er, output int lat, output int wrs);
    int w0;
    int guard;
    @(negedge clk);
    sel = s; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    w0 = wr_total;
    guard = 0;
    while (!o_req_ready && guard < 32) begin @(negedge clk); guard++; end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!o_rsp_valid && lat < 64) begin @(negedge clk); lat++; end
    rd = o_rsp_rdata;
    er = o_rsp_err;
    if (consume) begin
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
    wrs = wr_total - w0;
  endtask

  typedef struct {
    bit          s;
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_lat;
    int          exp_wr;
    logic [31:0] exp_mem;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  initial begin
    logic [31:0] rd;
    bit          er;
    int          lat;
    int          wrs;
    int          g;

    n_vec = 0; n_err = 0;
    rst_b = 1'b0; mem_load = 1'b1; sel = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;

    vecs[0]  = '{0, 0, 3'b000, 32'h103, 32'h0,        32'hFFFFFF88, 0, 2, 0, 32'h8899AABB};
    vecs[1]  = '{0, 0, 3'b100, 32'h103, 32'h0,        32'h00000088, 0, 2, 0, 32'h8899AABB};
    vecs[2]  = '{0, 0, 3'b001, 32'h102, 32'h0,        32'hFFFF8899, 0, 2, 0, 32'h8899AABB};
    vecs[3]  = '{0, 0, 3'b101, 32'h100, 32'h0,        32'h0000AABB, 0, 2, 0, 32'h8899AABB};
    vecs[4]  = '{0, 0, 3'b010, 32'h100, 32'h0,        32'h8899AABB, 0, 2, 0, 32'h8899AABB};
    vecs[5]  = '{0, 0, 3'b000, 32'h100, 32'h0,        32'hFFFFFFBB, 0, 2, 0, 32'h8899AABB};
    vecs[6]  = '{0, 1, 3'b000, 32'h101, 32'h123456CC, 32'h0,        0, 3, 1, 32'h8899CCBB};
    vecs[7]  = '{0, 0, 3'b010, 32'h100, 32'h0,        32'h8899CCBB, 0, 2, 0, 32'h8899CCBB};
    vecs[8]  = '{0, 1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0,        0, 2, 1, 32'hDEADBEEF};
    vecs[9]  = '{1, 0, 3'b010, 32'h104, 32'h0,        32'hDEADBEEF, 0, 4, 0, 32'hDEADBEEF};
    vecs[10] = '{1, 0, 3'b100, 32'h105, 32'h0,        32'h000000BE, 0, 4, 0, 32'hDEADBEEF};
    vecs[11] = '{1, 1, 3'b001, 32'h106, 32'h0000CAFE, 32'h0,        0, 5, 1, 32'hCAFEBEEF};
    vecs[12] = '{0, 0, 3'b001, 32'h106, 32'h0,        32'hFFFFCAFE, 0, 2, 0, 32'hCAFEBEEF};
    vecs[13] = '{0, 0, 3'b010, 32'h102, 32'h0,        32'h0,        1, 1, 0, 32'h8899CCBB};
    vecs[14] = '{0, 1, 3'b001, 32'h101, 32'h0000FFFF, 32'h0,        1, 1, 0, 32'h8899CCBB};
    vecs[15] = '{0, 0, 3'b011, 32'h100, 32'h0,        32'h0,        1, 1, 0, 32'h8899CCBB};
    vecs[16] = '{0, 1, 3'b100, 32'h100, 32'hFFFFFFFF, 32'h0,        1, 1, 0, 32'h8899CCBB};
    vecs[17] = '{0, 0, 3'b101, 32'h103, 32'h0,        32'h0,        1, 1, 0, 32'h8899CCBB};
    vecs[18] = '{0, 0, 3'b110, 32'h100, 32'h0,        32'h0,        1, 1, 0, 32'h8899CCBB};
    vecs[19] = '{1, 1, 3'b111, 32'h104, 32'h0,        32'h0,        1, 1, 0, 32'hCAFEBEEF};
    vecs[20] = '{1, 1, 3'b010, 32'h106, 32'h0,        32'h0,        1, 1, 0, 32'hCAFEBEEF};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1; mem_load = 1'b0;
    chk("rst_req_ready_a", 32'(rr_a), 32'd1);
    chk("rst_req_ready_b", 32'(rr_b), 32'd1);
    chk("rst_rsp_valid", 32'(rv_a), 32'd0);
    chk("rst_rsp_rdata", rd_a, 32'd0);
    chk("rst_rsp_err", 32'(re_a), 32'd0);
    chk("rst_mem_addr", maddr_a, 32'd0);
    chk("rst_mem_data_in", wr_word_a, 32'd0);
    chk("rst_mem_write_en", 32'(mwe_a), 32'd0);

    // Table-driven transactions
    for (int i = 0; i < NV; i++) begin
      txn(vecs[i].s, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, 1'b1, rd, er, lat, wrs);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("v%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d_write_cycles", i), 32'(wrs), 32'(vecs[i].exp_wr));
      chk($sformatf("v%0d_mem", i), mem[vecs[i].addr[9:2]], vecs[i].exp_mem);
    end

    // Response backpressure with a competing request pending
    txn(1'b0, 1'b0, 3'b001, 32'h102, 32'h0, 1'b0, rd, er, lat, wrs);
    chk("bp_rdata", rd, 32'hFFFF8899);
    chk("bp_latency", 32'(lat), 32'd2);
    req_we = 1'b0; req_funct3 = 3'b100; req_addr = 32'h100; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d_valid", i), 32'(o_rsp_valid), 32'd1);
      chk($sformatf("bp_hold%0d_rdata", i), o_rsp_rdata, 32'hFFFF8899);
      chk($sformatf("bp_hold%0d_req_ready", i), 32'(o_req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_consumed_valid", 32'(o_rsp_valid), 32'd0);
    chk("bp_not_accepted_on_consume", 32'(o_req_ready), 32'd1);
    @(negedge clk);
    chk("bp_accepted_next", 32'(o_req_ready), 32'd0);
    req_valid = 1'b0;
    lat = 1;
    while (!o_rsp_valid && lat < 64) begin @(negedge clk); lat++; end
    chk("bp_next_rdata", o_rsp_rdata, 32'h000000BB);
    chk("bp_next_latency", 32'(lat), 32'd2);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Reset during the write cycle of a read-modify-write store
    @(negedge clk);
    sel = 1'b0; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h102;
    req_wdata = 32'h00005555; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    g = 0;
    while (!mwe_a && g < 32) begin @(negedge clk); g++; end
    chk("rst_mid_write_seen", 32'(mwe_a), 32'd1);
    #1 rst_b = 1'b0;
    #1;
    chk("rst_mid_write_en_drop", 32'(mwe_a), 32'd0);
    chk("rst_mid_req_ready", 32'(rr_a), 32'd1);
    chk("rst_mid_rsp_valid", 32'(rv_a), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    chk("rst_mid_mem", mem[64], 32'h8899CCBB);
    chk("rst_rel_req_ready", 32'(rr_a), 32'd1);
    chk("rst_rel_rsp_valid", 32'(rv_a), 32'd0);
    txn(1'b0, 1'b0, 3'b010, 32'h100, 32'h0, 1'b1, rd, er, lat, wrs);
    chk("post_rst_rdata", rd, 32'h8899CCBB);
    chk("post_rst_latency", 32'(lat), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
